// File: rtl/mode_seq_pkg.sv
`default_nettype none
// ============================================================================
// mode_seq_pkg : shared helpers and reset-default tables for mode_sequencer
// Rev 1.0
// ============================================================================
package mode_seq_pkg;

   // Default patterns packed one nibble per entry, entry 0 in the LSBs.
   localparam logic [63:0] c_DEF_PAT_M0 = 64'h0000_1221_3203_3023;
   localparam logic [63:0] c_DEF_PAT_M1 = 64'h0000_0000_0000_0231;
   localparam logic [63:0] c_DEF_PAT_M2 = 64'h0000_0000_0003_2212;
   localparam logic [63:0] c_DEF_PAT_M3 = 64'h0000_0000_0000_0021;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic logic in_range(input int v, input int lim);
      return (v < lim);
   endfunction

   function automatic int default_len(input int mode);
      case (mode)
         0:       return 12;
         1:       return 4;
         2:       return 6;
         3:       return 2;
         default: return 1;
      endcase
   endfunction

   function automatic int default_pat(input int mode, input int addr);
      logic [63:0] p;
      case (mode)
         0:       p = c_DEF_PAT_M0;
         1:       p = c_DEF_PAT_M1;
         2:       p = c_DEF_PAT_M2;
         3:       p = c_DEF_PAT_M3;
         default: p = 64'h0;
      endcase
      p = p >> (4 * addr);
      return int'(p[3:0]);
   endfunction

   // A zero length would stall the step counter, so it is stored as one.
   function automatic int clamp_len(input int len, input int depth);
      if (len < 1)     return 1;
      if (len > depth) return depth;
      return len;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mode_seq_table.sv
`default_nettype none
// ============================================================================
// mode_seq_table : per-mode pattern register file and length registers
// Rev 1.0
// ============================================================================
module mode_seq_table
   import mode_seq_pkg::*;
#(
   parameter int  OUT_W = 2,
   parameter int  MODES = 4,
   parameter int  DEPTH = 16,
   localparam int MW    = clog2(MODES),
   localparam int SW    = clog2(DEPTH),
   localparam int LW    = clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_cfg_we,
   input  logic [MW-1:0]    i_cfg_mode,
   input  logic [SW-1:0]    i_cfg_addr,
   input  logic [OUT_W-1:0] i_cfg_data,
   input  logic             i_len_we,
   input  logic [LW-1:0]    i_len_data,
   input  logic [MW-1:0]    i_rd_mode,
   input  logic [SW-1:0]    i_rd_addr,
   output logic [OUT_W-1:0] o_rd_data,
   input  logic [MW-1:0]    i_len_mode,
   output logic [LW-1:0]    o_len
);

   logic [OUT_W-1:0] r_pat [MODES][DEPTH];
   logic [LW-1:0]    r_len [MODES];
   logic             w_mode_ok;
   logic             w_addr_ok;

   assign w_mode_ok = in_range(int'(i_cfg_mode), MODES);
   assign w_addr_ok = in_range(int'(i_cfg_addr), DEPTH);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int m = 0; m < MODES; m++) begin
            r_len[m] <= LW'(clamp_len(default_len(m), DEPTH));
            for (int a = 0; a < DEPTH; a++) begin
               r_pat[m][a] <= OUT_W'(default_pat(m, a));
            end
         end
      end else begin
         if (i_cfg_we && w_mode_ok && w_addr_ok) begin
            r_pat[i_cfg_mode][i_cfg_addr] <= i_cfg_data;
         end
         if (i_len_we && w_mode_ok) begin
            r_len[i_cfg_mode] <= LW'(clamp_len(int'(i_len_data), DEPTH));
         end
      end
   end

   // Reads see the pre-write contents when a write hits the same entry.
   assign o_rd_data = r_pat[i_rd_mode][i_rd_addr];
   assign o_len     = r_len[i_len_mode];

endmodule
`default_nettype wire

// File: rtl/mode_sequencer.sv
`default_nettype none
// ============================================================================
// mode_sequencer : multi-mode pattern sequencer, mode switches deferred to wrap
// Rev 1.0
// ============================================================================
module mode_sequencer
   import mode_seq_pkg::*;
#(
   parameter int  OUT_W = 2,
   parameter int  MODES = 4,
   parameter int  DEPTH = 16,
   localparam int MW    = clog2(MODES),
   localparam int SW    = clog2(DEPTH),
   localparam int LW    = clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic             i_restart,
   input  logic [MW-1:0]    i_mode_req,
   input  logic             i_mode_req_valid,
   output logic             o_mode_pending,
   input  logic             i_cfg_we,
   input  logic [MW-1:0]    i_cfg_mode,
   input  logic [SW-1:0]    i_cfg_addr,
   input  logic [OUT_W-1:0] i_cfg_data,
   input  logic             i_len_we,
   input  logic [LW-1:0]    i_len_data,
   output logic [OUT_W-1:0] o_z,
   output logic [SW-1:0]    o_step,
   output logic [MW-1:0]    o_cur_mode,
   output logic             o_wrap
);

   logic [SW-1:0]    r_step;
   logic [MW-1:0]    r_cur_mode;
   logic             r_pending;
   logic [MW-1:0]    r_pend_mode;
   logic             r_wrap;
   logic [OUT_W-1:0] r_z;

   logic [LW-1:0]    w_len;
   logic [LW-1:0]    w_step_inc;
   logic             w_last;
   logic             w_do_wrap;
   logic             w_req_ok;
   logic             w_pend_v;
   logic [MW-1:0]    w_pend_mode;
   logic [MW-1:0]    w_next_mode;
   logic [SW-1:0]    w_next_step;
   logic [OUT_W-1:0] w_rd_data;

   // ">=" rather than "==" so a length shortened below the current step wraps.
   assign w_step_inc  = LW'(r_step) + LW'(1);
   assign w_last      = (w_step_inc >= w_len);
   assign w_do_wrap   = i_restart | (i_en & w_last);

   // A request arriving on the wrap edge is applied by that same wrap.
   assign w_req_ok    = i_mode_req_valid & in_range(int'(i_mode_req), MODES);
   assign w_pend_v    = w_req_ok | r_pending;
   assign w_pend_mode = w_req_ok ? i_mode_req : r_pend_mode;
   assign w_next_mode = (w_do_wrap && w_pend_v) ? w_pend_mode : r_cur_mode;
   assign w_next_step = w_do_wrap ? '0 : SW'(w_step_inc);

   mode_seq_table #(
      .OUT_W (OUT_W),
      .MODES (MODES),
      .DEPTH (DEPTH)
   ) u_table (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_cfg_we   (i_cfg_we),
      .i_cfg_mode (i_cfg_mode),
      .i_cfg_addr (i_cfg_addr),
      .i_cfg_data (i_cfg_data),
      .i_len_we   (i_len_we),
      .i_len_data (i_len_data),
      .i_rd_mode  (w_next_mode),
      .i_rd_addr  (w_next_step),
      .o_rd_data  (w_rd_data),
      .i_len_mode (r_cur_mode),
      .o_len      (w_len)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_step      <= '0;
         r_cur_mode  <= '0;
         r_pending   <= 1'b0;
         r_pend_mode <= '0;
         r_wrap      <= 1'b0;
         r_z         <= OUT_W'(default_pat(0, 0));
      end else begin
         r_wrap <= w_do_wrap;
         if (w_do_wrap) begin
            r_pending  <= 1'b0;
            r_cur_mode <= w_next_mode;
         end else if (w_req_ok) begin
            r_pending  <= 1'b1;
         end
         if (w_req_ok) begin
            r_pend_mode <= i_mode_req;
         end
         if (w_do_wrap || i_en) begin
            r_step <= w_next_step;
            r_z    <= w_rd_data;
         end
      end
   end

   assign o_z            = r_z;
   assign o_step         = r_step;
   assign o_cur_mode     = r_cur_mode;
   assign o_wrap         = r_wrap;
   assign o_mode_pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_mode_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mode_sequencer : directed scenarios plus randomized run against a model
// Rev 1.0
// ============================================================================
module tb_mode_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       restart;
   logic [1:0] mode_req;
   logic       mode_req_valid;
   logic       mode_pending;
   logic       cfg_we;
   logic [1:0] cfg_mode;
   logic [3:0] cfg_addr;
   logic [1:0] cfg_data;
   logic       len_we;
   logic [4:0] len_data;
   logic [1:0] z;
   logic [3:0] step;
   logic [1:0] cur_mode;
   logic       wrap;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_pat [4][16];
   int m_len [4];
   int m_step, m_mode, m_pend, m_pend_mode, m_z, m_wrap;

   int def_pat [4][12] = '{'{3,2,0,3,3,0,2,3,1,2,2,1},
                           '{1,3,2,0,0,0,0,0,0,0,0,0},
                           '{2,1,2,2,3,0,0,0,0,0,0,0},
                           '{1,2,0,0,0,0,0,0,0,0,0,0}};
   int def_len [4] = '{12, 4, 6, 2};

   mode_sequencer #(.OUT_W(2), .MODES(4), .DEPTH(16)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_en             (en),
      .i_restart        (restart),
      .i_mode_req       (mode_req),
      .i_mode_req_valid (mode_req_valid),
      .o_mode_pending   (mode_pending),
      .i_cfg_we         (cfg_we),
      .i_cfg_mode       (cfg_mode),
      .i_cfg_addr       (cfg_addr),
      .i_cfg_data       (cfg_data),
      .i_len_we         (len_we),
      .i_len_data       (len_data),
      .o_z              (z),
      .o_step           (step),
      .o_cur_mode       (cur_mode),
      .o_wrap           (wrap)
   );

   always #5 clk = ~clk;

   // One clock edge of the behaviour: sequence decision first, table writes after.
   function automatic void model_edge();
      int do_wrap;
      if (!rst_n) begin
         for (int m = 0; m < 4; m++) begin
            m_len[m] = def_len[m];
            for (int a = 0; a < 16; a++) m_pat[m][a] = (a < 12) ? def_pat[m][a] : 0;
         end
         m_step = 0; m_mode = 0; m_pend = 0; m_pend_mode = 0; m_wrap = 0;
         m_z = m_pat[0][0];
      end else begin
         do_wrap = (restart || (en && (m_step >= m_len[m_mode] - 1))) ? 1 : 0;
         if (mode_req_valid) begin
            m_pend = 1;
            m_pend_mode = int'(mode_req);
         end
         m_wrap = do_wrap;
         if (do_wrap != 0) begin
            if (m_pend != 0) m_mode = m_pend_mode;
            m_pend = 0;
            m_step = 0;
            m_z = m_pat[m_mode][0];
         end else if (en) begin
            m_step = m_step + 1;
            m_z = m_pat[m_mode][m_step];
         end
         if (cfg_we) m_pat[int'(cfg_mode)][int'(cfg_addr)] = int'(cfg_data);
         if (len_we) begin
            if (len_data == 0)     m_len[int'(cfg_mode)] = 1;
            else if (len_data > 16) m_len[int'(cfg_mode)] = 16;
            else                   m_len[int'(cfg_mode)] = int'(len_data);
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      en = 1'b0; restart = 1'b0; mode_req = 2'd0; mode_req_valid = 1'b0;
      cfg_we = 1'b0; cfg_mode = 2'd0; cfg_addr = 4'd0; cfg_data = 2'd0;
      len_we = 1'b0; len_data = 5'd0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      checks++; if (z !== 2'd3)        begin errors++; $display("FAIL reset_z: got %0d expected 3", z); end
      checks++; if (step !== 4'd0)     begin errors++; $display("FAIL reset_step: got %0d expected 0", step); end
      checks++; if (cur_mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", cur_mode); end
      checks++; if (mode_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %0d expected 0", mode_pending); end
      checks++; if (wrap !== 1'b0)     begin errors++; $display("FAIL reset_wrap: got %0d expected 0", wrap); end
   endtask

   task automatic test_mode0_sequence();
      int exp_z [13] = '{3,2,0,3,3,0,2,3,1,2,2,1,3};
      for (int k = 1; k <= 12; k++) begin
         en = 1'b1;
         tick();
         checks++;
         if (z !== 2'(exp_z[k])) begin errors++; $display("FAIL mode0_z edge %0d: got %0d expected %0d", k, z, exp_z[k]); end
         checks++;
         if (wrap !== (k == 12)) begin errors++; $display("FAIL mode0_wrap edge %0d: got %0d expected %0d", k, wrap, (k == 12)); end
      end
      en = 1'b0;
   endtask

   task automatic test_deferred_mode();
      int exp_z [6] = '{2,1,2,2,3,0};
      int n;
      en = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      mode_req = 2'd2; mode_req_valid = 1'b1;
      tick();
      mode_req_valid = 1'b0;
      checks++;
      if (mode_pending !== 1'b1 || cur_mode !== 2'd0 || step !== 4'd6) begin
         errors++; $display("FAIL defer_pending: got pend %0d mode %0d step %0d expected 1 0 6", mode_pending, cur_mode, step);
      end
      n = 0;
      do begin
         tick(); n++;
         checks++;
         if (z !== 2'(m_z)) begin errors++; $display("FAIL defer_tail_z: got %0d expected %0d", z, m_z); end
      end while (!wrap && n < 40);
      checks++;
      if (!wrap || n != 6) begin errors++; $display("FAIL defer_wrap_edges: got %0d expected 6", n); end
      checks++;
      if (cur_mode !== 2'd2 || mode_pending !== 1'b0) begin errors++; $display("FAIL defer_switch: got mode %0d pend %0d expected 2 0", cur_mode, mode_pending); end
      for (int k = 0; k < 6; k++) begin
         if (k > 0) tick();
         checks++;
         if (z !== 2'(exp_z[k])) begin errors++; $display("FAIL defer_mode2_z %0d: got %0d expected %0d", k, z, exp_z[k]); end
      end
      en = 1'b0;
   endtask

   task automatic test_last_wins();
      int exp_z [4] = '{1,2,1,2};
      mode_req = 2'd1; mode_req_valid = 1'b1; tick();
      mode_req = 2'd3; tick();
      mode_req_valid = 1'b0;
      checks++;
      if (mode_pending !== 1'b1 || cur_mode !== 2'd2) begin errors++; $display("FAIL lastwins_hold: got pend %0d mode %0d expected 1 2", mode_pending, cur_mode); end
      en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (z !== 2'(exp_z[k]) || cur_mode !== 2'd3) begin errors++; $display("FAIL lastwins_z %0d: got z %0d mode %0d expected %0d 3", k, z, cur_mode, exp_z[k]); end
      end
      checks++;
      if (mode_pending !== 1'b0) begin errors++; $display("FAIL lastwins_clear: got %0d expected 0", mode_pending); end
      en = 1'b0;
   endtask

   task automatic test_len_write();
      int n;
      restart = 1'b1; mode_req = 2'd1; mode_req_valid = 1'b1; tick();
      restart = 1'b0; mode_req_valid = 1'b0;
      checks++;
      if (cur_mode !== 2'd1 || z !== 2'd1 || wrap !== 1'b1) begin errors++; $display("FAIL len_restart: got mode %0d z %0d wrap %0d expected 1 1 1", cur_mode, z, wrap); end
      en = 1'b1; tick(); tick(); tick(); en = 1'b0;
      len_we = 1'b1; cfg_mode = 2'd1; len_data = 5'd2; tick(); len_we = 1'b0;
      checks++;
      if (step !== 4'd3 || z !== 2'd0) begin errors++; $display("FAIL len_hold: got step %0d z %0d expected 3 0", step, z); end
      en = 1'b1; tick(); en = 1'b0;
      checks++;
      if (step !== 4'd0 || z !== 2'd1 || wrap !== 1'b1) begin errors++; $display("FAIL len_short_wrap: got step %0d z %0d wrap %0d expected 0 1 1", step, z, wrap); end
      len_we = 1'b1; len_data = 5'd0; tick(); len_we = 1'b0;
      en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (z !== 2'd1 || step !== 4'd0 || wrap !== 1'b1) begin errors++; $display("FAIL len_zero %0d: got z %0d step %0d wrap %0d expected 1 0 1", k, z, step, wrap); end
      end
      en = 1'b0;
      len_we = 1'b1; len_data = 5'd31; tick(); len_we = 1'b0;
      en = 1'b1; n = 0;
      do begin tick(); n++; end while (!wrap && n < 40);
      en = 1'b0;
      checks++;
      if (n != 16) begin errors++; $display("FAIL len_clamp_edges: got %0d expected 16", n); end
   endtask

   task automatic test_cfg_write_restart();
      restart = 1'b1; mode_req = 2'd3; mode_req_valid = 1'b1; tick();
      restart = 1'b0; mode_req_valid = 1'b0;
      en = 1'b1; tick(); en = 1'b0;
      cfg_we = 1'b1; cfg_mode = 2'd3; cfg_addr = 4'd1; cfg_data = 2'd0; tick(); cfg_we = 1'b0;
      checks++;
      if (z !== 2'd2 || step !== 4'd1) begin errors++; $display("FAIL cfg_keep_z: got z %0d step %0d expected 2 1", z, step); end
      en = 1'b1; tick(); tick();
      checks++;
      if (z !== 2'd0) begin errors++; $display("FAIL cfg_new_z: got %0d expected 0", z); end
      tick();
      cfg_we = 1'b1; cfg_data = 2'd3; tick(); cfg_we = 1'b0;
      checks++;
      if (z !== 2'd0) begin errors++; $display("FAIL cfg_same_cycle_old: got %0d expected 0", z); end
      tick(); tick();
      checks++;
      if (z !== 2'd3) begin errors++; $display("FAIL cfg_second_write: got %0d expected 3", z); end
      en = 1'b0; restart = 1'b1; tick(); restart = 1'b0;
      checks++;
      if (step !== 4'd0 || wrap !== 1'b1 || z !== 2'd1) begin errors++; $display("FAIL restart_no_en: got step %0d wrap %0d z %0d expected 0 1 1", step, wrap, z); end
   endtask

   task automatic test_reset_mid();
      int n;
      en = 1'b1; tick(); en = 1'b0;
      mode_req = 2'd2; mode_req_valid = 1'b1; tick(); mode_req_valid = 1'b0;
      checks++;
      if (mode_pending !== 1'b1) begin errors++; $display("FAIL rmid_pending: got %0d expected 1", mode_pending); end
      rst_n = 1'b0; cfg_we = 1'b1; cfg_mode = 2'd0; cfg_addr = 4'd0; cfg_data = 2'd1;
      len_we = 1'b1; len_data = 5'd3;
      tick();
      rst_n = 1'b1; cfg_we = 1'b0; len_we = 1'b0;
      checks++;
      if (step !== 4'd0 || cur_mode !== 2'd0 || z !== 2'd3 || mode_pending !== 1'b0) begin
         errors++; $display("FAIL rmid_state: got step %0d mode %0d z %0d pend %0d expected 0 0 3 0", step, cur_mode, z, mode_pending);
      end
      restart = 1'b1; tick(); restart = 1'b0;
      checks++;
      if (z !== 2'd3 || cur_mode !== 2'd0) begin errors++; $display("FAIL rmid_discard_write: got z %0d mode %0d expected 3 0", z, cur_mode); end
      restart = 1'b1; mode_req = 2'd3; mode_req_valid = 1'b1; tick();
      restart = 1'b0; mode_req_valid = 1'b0;
      en = 1'b1; tick(); en = 1'b0;
      checks++;
      if (z !== 2'd2) begin errors++; $display("FAIL rmid_tbl_restore: got %0d expected 2", z); end
      restart = 1'b1; mode_req = 2'd1; mode_req_valid = 1'b1; tick();
      restart = 1'b0; mode_req_valid = 1'b0;
      en = 1'b1; n = 0;
      do begin tick(); n++; end while (!wrap && n < 40);
      en = 1'b0;
      checks++;
      if (n != 4) begin errors++; $display("FAIL rmid_len_restore: got %0d expected 4", n); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         rst_n          = ($urandom_range(0, 99) != 0);
         en             = ($urandom_range(0, 3) != 0);
         restart        = ($urandom_range(0, 19) == 0);
         mode_req_valid = ($urandom_range(0, 9) == 0);
         mode_req       = 2'($urandom_range(0, 3));
         cfg_we         = ($urandom_range(0, 7) == 0);
         cfg_mode       = 2'($urandom_range(0, 3));
         cfg_addr       = 4'($urandom_range(0, 15));
         cfg_data       = 2'($urandom_range(0, 3));
         len_we         = ($urandom_range(0, 11) == 0);
         len_data       = 5'($urandom_range(0, 31));
         tick();
         checks++;
         if (z !== 2'(m_z) || step !== 4'(m_step) || cur_mode !== 2'(m_mode) ||
             wrap !== 1'(m_wrap) || mode_pending !== 1'(m_pend)) begin
            errors++;
            $display("FAIL random cycle %0d: got z %0d step %0d mode %0d wrap %0d pend %0d expected %0d %0d %0d %0d %0d",
                     i, z, step, cur_mode, wrap, mode_pending, m_z, m_step, m_mode, m_wrap, m_pend);
         end
      end
      idle_inputs();
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_mode0_sequence();
      test_deferred_mode();
      test_last_wins();
      test_len_write();
      test_cfg_write_restart();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
